mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
MIPS pipeline MEM stage: data memory plus the MEM/WB pipeline register. It sits directly upstream of the lw->sw store-data forward unit, which it feeds with the WB-stage destination register, the write enable, the mem-to-reg flag, and the MEM-stage store rt. It consumes the unit's forward select to pick the store data. It also drives the write-back result to the register file.

Parameters:
DATA_W, 32, data/address width in bits
MEM_AW, 8, word-address bits; memory depth = 2**MEM_AW words
CNT_W, 16, width of the saturating access counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high
ex_valid  input  1  EX/MEM holds a live instruction
ex_alu_result  input  DATA_W  byte address / ALU result
ex_store_data  input  DATA_W  rt value read in ID
ex_rt  input  5  rt of the instruction in MEM
ex_write_reg  input  5  destination register
ex_reg_write  input  1  instruction writes the register file
ex_mem_to_reg  input  1  load instruction
ex_mem_write  input  1  store instruction
stall  input  1  hold MEM/WB, block the memory write
flush  input  1  squash the MEM instruction
forward_f  input  1  from forward unit: use wb_result as store data
mem_rt  output  5  = ex_rt (RegSw to forward unit)
wb_write_reg  output  5  MEM/WB destination (RegLw)
wb_reg_write  output  1  MEM/WB write enable (WriteEnable)
wb_mem_to_reg  output  1  MEM/WB load flag (MemToRegWrite)
wb_result  output  DATA_W  write-back value
misalign_err  output  1  one-cycle pulse for a misaligned access
access_cnt  output  CNT_W  retired loads + stores, saturating

Behaviour:
- Effective store data (combinational):
  - forward_f=1 -> wb_result.
  - forward_f=0 -> ex_store_data.
- Word index = ex_alu_result[MEM_AW+1:2]. Higher address bits are ignored, so addresses wrap modulo the memory depth.
- Access is live when all of the following hold: ex_valid, !flush, !stall, !reset, and ex_alu_result[1:0]==0.
- Write: on the clk edge when the access is live and ex_mem_write=1, mem[index] <= effective store data.
- Read: synchronous. On the same edge, when the access is live and ex_mem_to_reg=1, wb_read_data <= mem[index].
- MEM/WB register update, in priority order:
  - reset: wb_valid, wb_reg_write, wb_mem_to_reg, wb_write_reg, wb_alu_result, wb_read_data all go to 0.
  - flush (priority over stall): wb_valid, wb_reg_write, wb_mem_to_reg go to 0; data fields don't-care.
  - stall: all fields hold.
  - otherwise: capture the ex_* fields. Control bits are ANDed with ex_valid.
- Misaligned access (ex_valid, a load or store, [1:0]!=0, not stalled or flushed):
  - Memory is untouched.
  - The instruction enters MEM/WB with wb_reg_write forced to 0.
  - misalign_err=1 for exactly the next cycle.
- Outputs to the forward unit:
  - wb_reg_write and wb_mem_to_reg are already qualified by wb_valid.
  - mem_rt is a direct pass-through of ex_rt.
- wb_result (combinational) = wb_mem_to_reg ? wb_read_data : wb_alu_result.
- access_cnt increments on each live aligned load or store. It saturates at 2**CNT_W-1.
- Reset values:
  - all wb_* outputs 0, wb_result 0, misalign_err 0, access_cnt 0.
  - memory contents are not reset.
- Latency:
  - store: 1 cycle to memory.
  - load: data appears on wb_result 1 cycle after the instruction is in MEM.
- Reset mid-operation: any store presented in the reset cycle is not written. MEM/WB clears on that edge.
- Simultaneous stall and flush: flush wins, and no memory write occurs.

Test Plan:
1. Forwarding path, lw r5,0(r0) then sw r5,4(r0), with mem[0]=0xDEADBEEF preloaded:
   - The bench asserts forward_f=1 when sw is in MEM.
   - Required: mem[1]=0xDEADBEEF, even though ex_store_data=0x0.
   - Forward-unit inputs during that cycle: wb_write_reg=5, wb_reg_write=1, wb_mem_to_reg=1, mem_rt=5.
2. Non-forward path: sw with forward_f=0, ex_store_data=0x12345678, addr 0x8 -> mem[2]=0x12345678; the following load from 0x8 returns 0x12345678 on wb_result one cycle later.
3. Misaligned access: load with addr 0x6 -> misalign_err high for exactly one cycle, wb_reg_write=0, access_cnt unchanged. A store to 0x6 leaves mem[1] unchanged.
4. Stall then flush:
   - stall=1 during a sw to 0xC -> mem[3] is not written and the MEM/WB outputs hold their previous values.
   - flush=1 together with stall=1 -> wb_reg_write=0, wb_mem_to_reg=0, no write.
5. Reset mid-operation: reset=1 in the same cycle as a valid sw to 0x10 -> mem[4] unchanged; all outputs and access_cnt are 0 on the next cycle.
6. Counter saturation: with CNT_W=4, 20 consecutive aligned accesses -> access_cnt stops at 15.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS MEM stage: word-addressed data memory plus the MEM/WB pipeline register,
// feeding the lw->sw store-data forward unit and the register-file write-back.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [4:0]        ex_rt,
    input  logic [4:0]        ex_write_reg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic              ex_mem_write,
    input  logic              stall,
    input  logic              flush,
    input  logic              forward_f,
    output logic [4:0]        mem_rt,
    output logic [4:0]        wb_write_reg,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [DATA_W-1:0] wb_result,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  access_cnt
);

    localparam int             DEPTH   = 1 << MEM_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [MEM_AW-1:0] index_s;
    logic              aligned_s;
    logic              is_mem_s;
    logic              go_s;
    logic              live_s;
    logic              misalign_s;
    logic [DATA_W-1:0] store_data_s;

    logic [4:0]        wb_write_reg_r;
    logic              wb_reg_write_r;
    logic              wb_mem_to_reg_r;
    logic [DATA_W-1:0] wb_alu_result_r;
    logic [DATA_W-1:0] wb_read_data_r;
    logic              misalign_err_r;
    logic [CNT_W-1:0]  access_cnt_r;

    // Address decode, access qualification, write-back mux and store-data forwarding
    always_comb begin
        index_s    = ex_alu_result[MEM_AW+1:2];
        aligned_s  = (ex_alu_result[1:0] == 2'b00);
        is_mem_s   = ex_mem_to_reg | ex_mem_write;
        go_s       = ex_valid & ~flush & ~stall & ~reset;
        live_s     = go_s & is_mem_s & aligned_s;
        misalign_s = go_s & is_mem_s & ~aligned_s;
        if (wb_mem_to_reg_r) begin
            wb_result = wb_read_data_r;
        end else begin
            wb_result = wb_alu_result_r;
        end
        // The forward unit picks the load result still sitting in WB
        if (forward_f) begin
            store_data_s = wb_result;
        end else begin
            store_data_s = ex_store_data;
        end
    end

    // Data memory write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (live_s && ex_mem_write) begin
            mem_r[index_s] <= store_data_s;
        end
    end

    // MEM/WB pipeline register with synchronous read of the data memory
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_write_reg_r  <= 5'd0;
            wb_reg_write_r  <= 1'b0;
            wb_mem_to_reg_r <= 1'b0;
            wb_alu_result_r <= {DATA_W{1'b0}};
            wb_read_data_r  <= {DATA_W{1'b0}};
        end else if (flush) begin
            wb_reg_write_r  <= 1'b0;
            wb_mem_to_reg_r <= 1'b0;
        end else if (!stall) begin
            wb_write_reg_r  <= ex_write_reg;
            wb_reg_write_r  <= ex_reg_write & ex_valid & ~(is_mem_s & ~aligned_s);
            wb_mem_to_reg_r <= ex_mem_to_reg & ex_valid;
            wb_alu_result_r <= ex_alu_result;
            if (live_s && ex_mem_to_reg) begin
                wb_read_data_r <= mem_r[index_s];
            end
        end
    end

    // Misalignment pulse and saturating retired-access counter
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err_r <= 1'b0;
            access_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            misalign_err_r <= misalign_s;
            if (live_s && (access_cnt_r != CNT_MAX)) begin
                access_cnt_r <= access_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign mem_rt        = ex_rt;
    assign wb_write_reg  = wb_write_reg_r;
    assign wb_reg_write  = wb_reg_write_r;
    assign wb_mem_to_reg = wb_mem_to_reg_r;
    assign misalign_err  = misalign_err_r;
    assign access_cnt    = access_cnt_r;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage: two instances (default and 4-bit counter) checked
// every cycle against a behavioural memory/pipeline model, plus directed scenarios.
module tb_mem_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write;
    logic        stall, flush, forward_f;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rt, ex_write_reg;

    logic [4:0]  a_mem_rt, a_wb_write_reg, b_mem_rt, b_wb_write_reg;
    logic        a_wb_reg_write, a_wb_mem_to_reg, a_misalign_err;
    logic        b_wb_reg_write, b_wb_mem_to_reg, b_misalign_err;
    logic [31:0] a_wb_result, b_wb_result;
    logic [15:0] a_access_cnt;
    logic [3:0]  b_access_cnt;

    mem_stage dut16 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .stall(stall), .flush(flush), .forward_f(forward_f), .mem_rt(a_mem_rt),
        .wb_write_reg(a_wb_write_reg), .wb_reg_write(a_wb_reg_write),
        .wb_mem_to_reg(a_wb_mem_to_reg), .wb_result(a_wb_result),
        .misalign_err(a_misalign_err), .access_cnt(a_access_cnt)
    );

    mem_stage #(.DATA_W(32), .MEM_AW(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rt(ex_rt), .ex_write_reg(ex_write_reg),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .stall(stall), .flush(flush), .forward_f(forward_f), .mem_rt(b_mem_rt),
        .wb_write_reg(b_wb_write_reg), .wb_reg_write(b_wb_reg_write),
        .wb_mem_to_reg(b_wb_mem_to_reg), .wb_result(b_wb_result),
        .misalign_err(b_misalign_err), .access_cnt(b_access_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [31:0] m_mem [256];
    logic        m_rw = 1'b0, m_m2r = 1'b0, m_err = 1'b0, m_flushed = 1'b0;
    logic [4:0]  m_wreg = 5'd0, m_rt = 5'd0;
    logic [31:0] m_alu = 32'd0, m_rd = 32'd0;
    int          m_cnt = 0, m_cnt4 = 0;
    logic [31:0] pre3, pre4;

    function automatic logic [31:0] m_result();
        return m_m2r ? m_rd : m_alu;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (check_en) begin
            chk("mem_rt16", {27'd0, a_mem_rt}, {27'd0, m_rt});
            chk("mem_rt4", {27'd0, b_mem_rt}, {27'd0, m_rt});
            chk("reg_write16", {31'd0, a_wb_reg_write}, {31'd0, m_rw});
            chk("reg_write4", {31'd0, b_wb_reg_write}, {31'd0, m_rw});
            chk("mem_to_reg16", {31'd0, a_wb_mem_to_reg}, {31'd0, m_m2r});
            chk("mem_to_reg4", {31'd0, b_wb_mem_to_reg}, {31'd0, m_m2r});
            chk("misalign16", {31'd0, a_misalign_err}, {31'd0, m_err});
            chk("misalign4", {31'd0, b_misalign_err}, {31'd0, m_err});
            chk("cnt16", {16'd0, a_access_cnt}, m_cnt);
            chk("cnt4", {28'd0, b_access_cnt}, m_cnt4);
            if (!m_flushed) begin
                chk("write_reg16", {27'd0, a_wb_write_reg}, {27'd0, m_wreg});
                chk("write_reg4", {27'd0, b_wb_write_reg}, {27'd0, m_wreg});
                chk("result16", a_wb_result, m_result());
                chk("result4", b_wb_result, m_result());
            end
        end
    end

    task automatic apply(input bit v, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rt, input logic [4:0] wr, input bit rw,
                         input bit m2r, input bit mw, input bit st, input bit fl,
                         input bit ff, input bit rs);
        ex_valid = v; ex_alu_result = a; ex_store_data = sd; ex_rt = rt;
        ex_write_reg = wr; ex_reg_write = rw; ex_mem_to_reg = m2r; ex_mem_write = mw;
        stall = st; flush = fl; forward_f = ff; reset = rs;
        m_rt = rt;
    endtask

    // One clock edge; the model advances from the inputs held across that edge
    task automatic cyc();
        logic [31:0] sd;
        logic [7:0]  idx;
        bit          go, ismem, al;
        @(posedge clk);
        #1;
        sd    = forward_f ? m_result() : ex_store_data;
        idx   = ex_alu_result[9:2];
        ismem = ex_mem_to_reg || ex_mem_write;
        al    = (ex_alu_result[1:0] == 2'b00);
        if (reset) begin
            m_rw = 1'b0; m_m2r = 1'b0; m_err = 1'b0; m_flushed = 1'b0;
            m_wreg = 5'd0; m_alu = 32'd0; m_rd = 32'd0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            go    = ex_valid && !flush && !stall;
            m_err = go && ismem && !al;
            if (go && ismem && al) begin
                if (ex_mem_to_reg) m_rd = m_mem[idx];
                if (ex_mem_write) m_mem[idx] = sd;
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush) begin
                m_rw = 1'b0; m_m2r = 1'b0; m_flushed = 1'b1;
            end else if (!stall) begin
                m_rw = ex_valid && ex_reg_write && !(ismem && !al);
                m_m2r = ex_valid && ex_mem_to_reg;
                m_wreg = ex_write_reg;
                m_alu = ex_alu_result;
                m_flushed = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rt, input logic [4:0] wr, input bit rw,
                         input bit m2r, input bit mw, input bit st, input bit fl,
                         input bit ff, input bit rs);
        apply(v, a, sd, rt, wr, rw, m2r, mw, st, fl, ff, rs);
        cyc();
    endtask

    initial begin
        logic [31:0] a;
        int          kind, c0;
        bit          v, st, fl, ff, rs, rw;

        apply(1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc();
        check_en = 1'b1;
        cyc();
        chk("rst_result", a_wb_result, 32'd0);
        chk("rst_cnt", {16'd0, a_access_cnt}, 32'd0);

        // Preload every word so later loads are fully defined
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, i << 2, $urandom, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        pre3 = m_mem[3];
        pre4 = m_mem[4];

        // lw r5,0(r0) then sw r5,4(r0) with store data forwarded from WB
        drive(1'b1, 32'h0, 32'hDEADBEEF, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 32'h0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 32'h4, 32'h0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("t1_wreg", {27'd0, a_wb_write_reg}, 32'd5);
        chk("t1_rw", {31'd0, a_wb_reg_write}, 32'd1);
        chk("t1_m2r", {31'd0, a_wb_mem_to_reg}, 32'd1);
        chk("t1_rt", {27'd0, a_mem_rt}, 32'd5);
        chk("t1_fwd", a_wb_result, 32'hDEADBEEF);
        cyc();
        drive(1'b1, 32'h4, 32'h0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_mem1", a_wb_result, 32'hDEADBEEF);

        // Non-forwarded store then load back
        drive(1'b1, 32'h8, 32'h12345678, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h8, 32'h0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_load", a_wb_result, 32'h12345678);

        // Misaligned load and store
        c0 = a_access_cnt;
        drive(1'b1, 32'h6, 32'h0, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_err", {31'd0, a_misalign_err}, 32'd1);
        chk("t3_rw", {31'd0, a_wb_reg_write}, 32'd0);
        chk("t3_cnt", {16'd0, a_access_cnt}, c0);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_pulse", {31'd0, a_misalign_err}, 32'd0);
        drive(1'b1, 32'h6, 32'hCAFEF00D, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h4, 32'h0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_mem1", a_wb_result, 32'hDEADBEEF);

        // Stall holds MEM/WB and blocks the write; flush beats stall
        drive(1'b1, 32'h8, 32'h0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 32'h55AA55AA, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t4_hold_res", a_wb_result, 32'h12345678);
        chk("t4_hold_rw", {31'd0, a_wb_reg_write}, 32'd1);
        chk("t4_hold_wr", {27'd0, a_wb_write_reg}, 32'd7);
        drive(1'b1, 32'hC, 32'h55AA55AA, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_fl_rw", {31'd0, a_wb_reg_write}, 32'd0);
        chk("t4_fl_m2r", {31'd0, a_wb_mem_to_reg}, 32'd0);
        drive(1'b1, 32'hC, 32'h0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_mem3", a_wb_result, pre3);

        // Reset in the same cycle as a store
        drive(1'b1, 32'h10, 32'h0BADBEEF, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_res", a_wb_result, 32'd0);
        chk("t5_rw", {31'd0, a_wb_reg_write}, 32'd0);
        chk("t5_cnt", {16'd0, a_access_cnt}, 32'd0);
        chk("t5_cnt4", {28'd0, b_access_cnt}, 32'd0);
        drive(1'b1, 32'h10, 32'h0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_mem4", a_wb_result, pre4);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            kind = $urandom_range(0, 2);
            v  = ($urandom_range(0, 5) != 0);
            st = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 9) == 0);
            ff = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 99) == 0);
            rw = (kind == 1) ? 1'b1 : ((kind == 2) ? 1'b0 : 1'($urandom_range(0, 1)));
            drive(v, a, $urandom, 5'($urandom), 5'($urandom), rw, kind == 1, kind == 2,
                  st, fl, ff, rs);
        end

        // Counter saturation on the 4-bit instance
        drive(1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, i << 2, $urandom, 5'd1, 5'd2, i[0], i[0], !i[0],
                  1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("t6_sat4", {28'd0, b_access_cnt}, 32'd15);
        chk("t6_cnt16", {16'd0, a_access_cnt}, 32'd20);

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
